// File: rtl/instruction_loader.sv
// instruction_loader
//   Byte-stream program loader that owns the write side of the instruction memory.
//   The stream carries a 2-byte little-endian word count N followed by 4*N little-endian
//   instruction bytes. Each completed word is written to memory with a one-cycle strobe.
//   The core is held in reset while a load is in progress or has failed.
//
//   Optional feature: define CHECKSUM_EN to require one trailing byte equal to the XOR of
//   all data bytes (0x00 when N==0). A match ends in DONE and a mismatch ends in ERR.
//
// Ports
//   clock      in   1   rising-edge clock
//   reset      in   1   asynchronous, active-high
//   start      in   1   begin a load (honoured in IDLE, DONE, ERR)
//   byteValid  in   1   byteData is valid
//   byteData   in   8   stream byte
//   byteReady  out  1   loader accepts a byte this cycle
//   imemWrite  out  1   one-cycle instruction memory write strobe
//   imemAddr   out  32  write byte address (BASE_ADDR + 4*k)
//   imemData   out  32  assembled instruction word
//   coreReset  out  1   hold the datapath in reset
//   done       out  1   load completed successfully
//   error      out  1   load aborted
module instruction_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        byteValid,
    input  logic [7:0]  byteData,
    output logic        byteReady,
    output logic        imemWrite,
    output logic [31:0] imemAddr,
    output logic [31:0] imemData,
    output logic        coreReset,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StData,
        StWrite,
        StDone,
`ifdef CHECKSUM_EN
        StCsum,
`endif
        StErr
    } state_e;

    state_e      state_q;
    logic [15:0] count_q;     // word count N from the header
    logic [15:0] words_q;     // words completed so far
    logic [1:0]  byte_idx_q;  // byte position within the current word
    logic [23:0] asm_q;       // lower three bytes of the word being assembled
`ifdef CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        xfer;
    logic [15:0] hdr_n;
    logic        hdr_too_big;

    assign xfer        = byteValid & byteReady;
    assign hdr_n       = {byteData, count_q[7:0]};
    assign hdr_too_big = {16'h0000, hdr_n} > MAX_WORDS;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            words_q    <= '0;
            byte_idx_q <= '0;
            asm_q      <= '0;
`ifdef CHECKSUM_EN
            csum_q     <= '0;
`endif
            byteReady  <= 1'b0;
            imemWrite  <= 1'b0;
            imemAddr   <= BASE_ADDR;
            imemData   <= '0;
            coreReset  <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imemWrite <= 1'b0;
            case (state_q)
                StIdle, StDone, StErr: begin
                    // byteReady is low here, so a byte offered alongside start is not taken
                    if (start) begin
                        state_q    <= StHdr0;
                        count_q    <= '0;
                        words_q    <= '0;
                        byte_idx_q <= '0;
                        asm_q      <= '0;
`ifdef CHECKSUM_EN
                        csum_q     <= '0;
`endif
                        imemAddr   <= BASE_ADDR;
                        byteReady  <= 1'b1;
                        coreReset  <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                    end
                end
                StHdr0: begin
                    if (xfer) begin
                        count_q[7:0] <= byteData;
                        state_q      <= StHdr1;
                    end
                end
                StHdr1: begin
                    if (xfer) begin
                        count_q <= hdr_n;
                        if (hdr_too_big) begin
                            state_q   <= StErr;
                            byteReady <= 1'b0;
                            error     <= 1'b1;
                        end else if (hdr_n == 16'd0) begin
`ifdef CHECKSUM_EN
                            state_q   <= StCsum;
`else
                            state_q   <= StDone;
                            byteReady <= 1'b0;
                            coreReset <= 1'b0;
                            done      <= 1'b1;
`endif
                        end else begin
                            state_q <= StData;
                        end
                    end
                end
                StData: begin
                    if (xfer) begin
`ifdef CHECKSUM_EN
                        csum_q <= csum_q ^ byteData;
`endif
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            imemData  <= {byteData, asm_q};
                            imemWrite <= 1'b1;
                            words_q   <= words_q + 16'd1;
                            byteReady <= 1'b0;
                            state_q   <= StWrite;
                        end else begin
                            asm_q[8*byte_idx_q +: 8] <= byteData;
                        end
                    end
                end
                StWrite: begin
                    // Address advances after the strobe cycle so it matches the word just written
                    imemAddr <= imemAddr + 32'd4;
                    if (words_q == count_q) begin
`ifdef CHECKSUM_EN
                        state_q   <= StCsum;
                        byteReady <= 1'b1;
`else
                        state_q   <= StDone;
                        coreReset <= 1'b0;
                        done      <= 1'b1;
`endif
                    end else begin
                        state_q   <= StData;
                        byteReady <= 1'b1;
                    end
                end
`ifdef CHECKSUM_EN
                StCsum: begin
                    if (xfer) begin
                        byteReady <= 1'b0;
                        if (byteData == csum_q) begin
                            state_q   <= StDone;
                            coreReset <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state_q <= StErr;
                            error   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state_q   <= StIdle;
                    byteReady <= 1'b0;
                    coreReset <= 1'b0;
                end
            endcase
        end
    end

endmodule
